fb_write_arbiter: RTL and testbench

Shares the single framebuffer write port between several pixel producers: background clear, rasterizer pixel stream and overlay writers. Each producer presents a valid/ready write stream. The arbiter grants one producer at a time in round-robin order and holds the grant for a bounded burst. Accepted writes are forwarded through one registered stage to the buffer write port. It sits between the drawing pipeline's producers and the double-buffered frame memory.

---
 rtl/fb_write_arbiter.sv | 150 +++++++++++++++
 tb/tb_fb_write_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Round-robin framebuffer write arbiter: bounded bursts, 1-cycle registered write port, ready held low while arb_enable is low.
// Optional per-requester beat counters are built only when FB_ARB_PERF_COUNTERS_EN is defined.
module fb_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 12,
  parameter int MAX_BURST  = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             arb_enable,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic                             write_en,
  output logic [ADDR_WIDTH-1:0]            write_addr,
  output logic [DATA_WIDTH-1:0]            write_data,
  output logic                             grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  input  logic                             counter_clear,
  output logic [NUM_REQ*16-1:0]            beat_count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant, last_nxt, gid_nxt;
  logic [BW-1:0]  burst_cnt, burst_nxt;
  logic [IDW-1:0] rr_winner;
  logic           rr_found;
  logic           owner_valid, owner_last, accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    int idx;
    idx       = 0;
    rr_winner = '0;
    rr_found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!rr_found && req_valid[idx]) begin
        rr_found  = 1'b1;
        rr_winner = IDW'(idx);
      end
    end
  end

  assign owner_valid = req_valid[grant_id];
  assign owner_last  = req_last[grant_id];
  assign grant_valid = (state == GRANT);
  assign accept      = grant_valid && arb_enable && owner_valid;
  assign sel_addr    = req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data    = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    req_ready = '0;
    if (state == GRANT) req_ready[grant_id] = arb_enable;
  end

  always_comb begin
    state_nxt = state;
    gid_nxt   = grant_id;
    last_nxt  = last_grant;
    burst_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (rr_found) begin
          state_nxt = GRANT;
          gid_nxt   = rr_winner;
          last_nxt  = rr_winner;
          burst_nxt = '0;
        end
      end
      GRANT: begin
        // With arb_enable low everything freezes, including the valid-drop release.
        if (arb_enable) begin
          if (!owner_valid) begin
            state_nxt = IDLE;
          end else begin
            burst_nxt = burst_cnt + BW'(1);
            if (owner_last || (burst_cnt == BW'(MAX_BURST - 1))) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= gid_nxt;
      last_grant <= last_nxt;
      burst_cnt  <= burst_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      write_en <= accept;
      if (accept) begin
        write_addr <= sel_addr;
        write_data <= sel_data;
      end
    end
  end

`ifdef FB_ARB_PERF_COUNTERS_EN
  logic [15:0] cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (counter_clear)
          cnt[i] <= '0;
        else if (accept && (grant_id == IDW'(i)) && (cnt[i] != 16'hFFFF))
          cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    beat_count = '0;
    for (int i = 0; i < NUM_REQ; i++) beat_count[i*16 +: 16] = cnt[i];
  end
`else
  logic unused_counter_clear;
  assign unused_counter_clear = counter_clear;
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: per-cycle producer model, write/grant logs, hand-computed expectations.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        arb_enable;
  logic [2:0]  req_valid, req_ready, req_last;
  logic [44:0] req_addr;
  logic [35:0] req_data;
  logic        write_en;
  logic [14:0] write_addr;
  logic [11:0] write_data;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        counter_clear;
  logic [47:0] beat_count;

  fb_write_arbiter dut (
    .clk(clk), .rstn(rstn), .arb_enable(arb_enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .counter_clear(counter_clear), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          rem [3];
  logic [14:0] base [3];
  bit          use_last [3];
  bit          en_next, cc_next, gv_prev;
  logic [2:0]  fire;
  int          cyc;
  logic [14:0] wa [$];
  logic [11:0] wd [$];
  int          wc [$];
  logic [1:0]  gq [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] mkdata(input int i, input logic [14:0] a);
    return {i[1:0], a[9:0]};
  endfunction

  function automatic int wid(input int k);
    return (k < wd.size()) ? int'(wd[k][11:10]) : 7;
  endfunction

  function automatic int wcy(input int k);
    return (k < wc.size()) ? wc[k] : -1000;
  endfunction

  function automatic int gget(input int k);
    return (k < gq.size()) ? int'(gq[k]) : 7;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = rem[i] > 0;
      req_last[i]  = use_last[i] && (rem[i] == 1);
      req_addr[i*15 +: 15] = base[i];
      req_data[i*12 +: 12] = mkdata(i, base[i]);
    end
    arb_enable    = en_next;
    counter_clear = cc_next;
  endtask

  // One clock: advance producers that handshook, drive, then observe at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      if (fire[i]) begin
        rem[i]--;
        base[i]++;
      end
    apply_inputs();
    @(negedge clk);
    cyc++;
    fire = req_valid & req_ready;
    if (write_en) begin
      wa.push_back(write_addr);
      wd.push_back(write_data);
      wc.push_back(cyc);
    end
    if (grant_valid && !gv_prev) gq.push_back(grant_id);
    gv_prev = grant_valid;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0;
      base[i] = 15'(i * 1000);
      use_last[i] = 1'b0;
    end
    en_next = 1'b1;
    cc_next = 1'b0;
    fire = '0;
    apply_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    wa.delete(); wd.delete(); wc.delete(); gq.delete();
    gv_prev = 1'b0;
    cyc = 0;
    @(negedge clk);
  endtask

  initial begin
    do_reset();

    // Reset state
    check("rst_write_en", write_en, 0);
    check("rst_write_addr", write_addr, 0);
    check("rst_write_data", write_data, 0);
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_beat_count", beat_count, 0);

    // Single requester, 5 beats at 100..104 with last on the fifth
    rem[1] = 5; base[1] = 15'd100; use_last[1] = 1'b1;
    tick();
    check("t1_ready_before_grant", req_ready, 0);
    tick();
    check("t1_grant_valid", grant_valid, 1);
    check("t1_grant_id", grant_id, 1);
    check("t1_ready", req_ready, 3'b010);
    check("t1_no_write_yet", write_en, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t1_wen_%0d", k), write_en, 1);
      check($sformatf("t1_addr_%0d", k), write_addr, 100 + k);
      check($sformatf("t1_data_%0d", k), write_data, {2'd1, 10'(100 + k)});
    end
    check("t1_idle_after_last", grant_valid, 0);
    tick();
    check("t1_wen_after", write_en, 0);
`ifndef FB_ARB_PERF_COUNTERS_EN
    check("t1_counters_tied", beat_count, 0);
`endif

    // Round robin, all three continuously valid
    do_reset();
    rem[0] = 1000; rem[1] = 1000; rem[2] = 1000;
    ticks(80);
    check("t2_g0", gget(0), 0);
    check("t2_g1", gget(1), 1);
    check("t2_g2", gget(2), 2);
    check("t2_g3", gget(3), 0);
    for (int g = 0; g < 3; g++) begin
      int n;
      n = 0;
      for (int k = 16 * g; k < 16 * g + 16; k++) if (wid(k) == g) n++;
      check($sformatf("t2_beats_req%0d", g), n, 16);
    end
    check("t2_burst_span", wcy(15) - wcy(0), 15);
    check("t2_gap_0_1", wcy(16) - wcy(15), 2);
    check("t2_gap_1_2", wcy(32) - wcy(31), 2);
    check("t2_req0_resume_addr", (wa.size() > 48) ? wa[48] : 15'h7fff, 16);

    // Last coincides with the burst limit
    do_reset();
    rem[0] = 16; use_last[0] = 1'b1;
    rem[1] = 3;  use_last[1] = 1'b1;
    ticks(40);
    check("t3_grants", gq.size(), 2);
    check("t3_first", gget(0), 0);
    check("t3_second", gget(1), 1);
    check("t3_writes", wa.size(), 19);
    check("t3_id15", wid(15), 0);
    check("t3_id16", wid(16), 1);
    check("t3_gap", wcy(16) - wcy(15), 2);

    // arb_enable low for three cycles mid-burst of req 2
    do_reset();
    rem[2] = 10; base[2] = 15'd500; use_last[2] = 1'b1;
    for (int k = 0; k < 20 && wa.size() < 4; k++) tick();
    check("t4_reach_4_beats", wa.size(), 4);
    en_next = 1'b0;
    tick();
    check("t4_ready_low_0", req_ready, 0);
    check("t4_inflight_write", write_en, 1);
    for (int k = 1; k < 3; k++) begin
      tick();
      check($sformatf("t4_ready_low_%0d", k), req_ready, 0);
      check($sformatf("t4_no_write_%0d", k), write_en, 0);
      check($sformatf("t4_gid_%0d", k), grant_id, 2);
      check($sformatf("t4_gvalid_%0d", k), grant_valid, 1);
    end
    en_next = 1'b1;
    tick();
    check("t4_no_write_3", write_en, 0);
    check("t4_ready_back", req_ready, 3'b100);
    ticks(20);
    check("t4_writes", wa.size(), 10);
    check("t4_last_addr", (wa.size() > 9) ? wa[9] : 15'h7fff, 509);
    check("t4_single_grant", gq.size(), 1);
    check("t4_released", grant_valid, 0);

    // Requester 0 drops valid after 3 beats
    do_reset();
    rem[0] = 3;
    rem[1] = 2; use_last[1] = 1'b1;
    ticks(20);
    check("t5_first", gget(0), 0);
    check("t5_second", gget(1), 1);
    check("t5_writes", wa.size(), 5);
    check("t5_id2", wid(2), 0);
    check("t5_id3", wid(3), 1);
    check("t5_gap", wcy(3) - wcy(2), 3);

    // Asynchronous reset in the middle of a burst
    do_reset();
    rem[1] = 50; base[1] = 15'd300;
    ticks(6);
    check("t6_bursting", write_en, 1);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_wen", write_en, 0);
    check("t6_rst_gvalid", grant_valid, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_addr", write_addr, 0);
    check("t6_rst_data", write_data, 0);
    do_reset();
    rem[0] = 2; use_last[0] = 1'b1;
    rem[2] = 2; use_last[2] = 1'b1;
    ticks(15);
    check("t6_first_after_rst", gget(0), 0);
    check("t6_second_after_rst", gget(1), 2);

`ifdef FB_ARB_PERF_COUNTERS_EN
    do_reset();
    check("t7_cnt_zero", beat_count, 0);
    rem[0] = 1000000;
    ticks(69700);
    check("t7_cnt0_sat", beat_count[15:0], 16'hFFFF);
    check("t7_cnt1_zero", beat_count[31:16], 0);
    cc_next = 1'b1;
    ticks(2);
    check("t7_cleared", beat_count, 0);
    cc_next = 1'b0;
    ticks(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
